sat_alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the combinational ALU datapath. It performs saturating add/sub, per-lane saturating add (PADDSB), byte reduction (RED), XOR and NAND on W-bit operands. Operands enter and results leave through valid/ready handshakes, and the block keeps a Z/V/N flag register. It sits between decode/operand fetch and writeback in the multi-cycle execute path.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/sat_add.sv | 31 +++
 rtl/sat_alu_pipe.sv | 180 ++++++++++++++++++
 tb/tb_sat_alu_pipe.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and saturation helpers for the
// pipelined saturating ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_XOR    = 3'b010,
        ALU_NAND   = 3'b011,
        ALU_PADDSB = 3'b100,
        ALU_RED    = 3'b101
    } alu_op_e;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    function automatic logic [63:0] sat_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: clamps to max/min when both operands
// share a sign and the raw sum's sign differs.
module sat_add
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         ovf
);

    localparam logic [63:0] MAX64 = sat_max(N);
    localparam logic [63:0] MIN64 = sat_min(N);
    localparam logic [N-1:0] MAXV = MAX64[N-1:0];
    localparam logic [N-1:0] MINV = MIN64[N-1:0];

    logic [N-1:0] raw;

    always_comb begin
        raw = x + y + {{(N-1){1'b0}}, cin};
        ovf = (x[N-1] == y[N-1]) && (raw[N-1] != x[N-1]);
        sum = raw;
        if (ovf) begin
            sum = x[N-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/sat_alu_pipe.sv
// Two-stage valid/ready ALU: S1 does adders and byte pair sums,
// S2 finishes the byte reduction and owns the result registers.
module sat_alu_pipe
    import alu_pkg::*;
#(
    parameter int W    = 16,
    parameter int LANE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         illegal,
    output logic [2:0]   flags
);

    localparam int NL = W / LANE;
    localparam int NP = W / 8;

    logic s2_adv, s1_adv;

    logic                s1_valid_q, s1_valid_d;
    logic [2:0]          s1_op_q, s1_op_d;
    logic [W-1:0]        s1_res_q, s1_res_d;
    logic                s1_ovf_q, s1_ovf_d;
    logic [NP-1:0][8:0]  s1_pair_q, s1_pair_d;

    logic                s2_valid_q, s2_valid_d;
    logic [2:0]          s2_op_q, s2_op_d;
    logic [W-1:0]        s2_res_q, s2_res_d;
    logic                s2_ovf_q, s2_ovf_d;
    logic                s2_ill_q, s2_ill_d;
    logic [2:0]          flags_q, flags_d;

    logic                is_sub;
    logic [W-1:0]        add_y, add_sum, lane_sum, red_sum;
    logic                add_ovf;
    logic [NL-1:0]       lane_ovf;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    assign is_sub = (op == ALU_SUB);
    assign add_y  = is_sub ? ~b : b;

    sat_add #(.N(W)) u_add (
        .x   (a),
        .y   (add_y),
        .cin (is_sub),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    for (genvar g = 0; g < NL; g++) begin : g_lane
        sat_add #(.N(LANE)) u_lane (
            .x   (a[g*LANE +: LANE]),
            .y   (b[g*LANE +: LANE]),
            .cin (1'b0),
            .sum (lane_sum[g*LANE +: LANE]),
            .ovf (lane_ovf[g])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_res_d   = s1_res_q;
        s1_ovf_d   = s1_ovf_q;
        s1_pair_d  = s1_pair_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = op;
                s1_res_d = '0;
                s1_ovf_d = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    s1_pair_d[i] = {a[8*i+7], a[8*i +: 8]}
                                 + {b[8*i+7], b[8*i +: 8]};
                end
                case (op)
                    ALU_ADD, ALU_SUB: begin
                        s1_res_d = add_sum;
                        s1_ovf_d = add_ovf;
                    end
                    ALU_XOR:  s1_res_d = a ^ b;
                    ALU_NAND: s1_res_d = ~(a & b);
                    ALU_PADDSB: begin
                        s1_res_d = lane_sum;
                        s1_ovf_d = |lane_ovf;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pair sums are 9-bit signed; W >= 16 keeps the full sum exact.
    always_comb begin
        red_sum = '0;
        for (int i = 0; i < NP; i++) begin
            red_sum = red_sum + {{(W-9){s1_pair_q[i][8]}}, s1_pair_q[i]};
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_op_d    = s2_op_q;
        s2_res_d   = s2_res_q;
        s2_ovf_d   = s2_ovf_q;
        s2_ill_d   = s2_ill_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_op_d  = s1_op_q;
                s2_ovf_d = s1_ovf_q;
                s2_ill_d = s1_op_q[2] & s1_op_q[1];
                if (s2_ill_d) begin
                    s2_res_d = '0;
                end else if (s1_op_q == ALU_RED) begin
                    s2_res_d = red_sum;
                end else begin
                    s2_res_d = s1_res_q;
                end
            end
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (s2_valid_q && out_ready) begin
            case (s2_op_q)
                ALU_ADD, ALU_SUB: begin
                    flags_d[FLG_Z] = (s2_res_q == '0);
                    flags_d[FLG_V] = s2_ovf_q;
                    flags_d[FLG_N] = s2_res_q[W-1];
                end
                ALU_XOR, ALU_NAND: flags_d[FLG_Z] = (s2_res_q == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_ill_q   <= 1'b0;
            flags_q    <= 3'b000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_ill_q   <= s2_ill_d;
            flags_q    <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_op_q   <= s1_op_d;
        s1_res_q  <= s1_res_d;
        s1_ovf_q  <= s1_ovf_d;
        s1_pair_q <= s1_pair_d;
        s2_op_q   <= s2_op_d;
        s2_ovf_q  <= s2_ovf_d;
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign illegal   = s2_ill_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_sat_alu_pipe.sv
// Directed bench for sat_alu_pipe at W=16, LANE=4 with
// hand-computed results, flags, back-pressure and reset cases.
module tb_sat_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        illegal;
    logic [2:0]  flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sat_alu_pipe #(.W(16), .LANE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input string tag, input logic [2:0] o,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic ei,
                        input logic [2:0] ef);
        op = o; a = x; b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".v1"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".v2"}, 32'(out_valid), 32'd1);
        chk({tag, ".res"}, 32'(result), 32'(er));
        chk({tag, ".ill"}, 32'(illegal), 32'(ei));
        step();
        chk({tag, ".flg"}, 32'(flags), 32'(ef));
        chk({tag, ".v3"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'b000; a = '0; b = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.res", 32'(result), 32'd0);
        chk("rst.ill", 32'(illegal), 32'd0);
        chk("rst.flg", 32'(flags), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd1);

        exec("add_sat", 3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 3'b010);
        exec("sub_sat", 3'b001, 16'h8000, 16'h0001, 16'h8000, 1'b0, 3'b011);
        exec("xor_z", 3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b111);
        exec("paddsb", 3'b100, 16'h7181, 16'h1181, 16'h7282, 1'b0, 3'b111);
        exec("red1", 3'b101, 16'h7F80, 16'h0101, 16'h0001, 1'b0, 3'b111);
        exec("red2", 3'b101, 16'h8080, 16'h8080, 16'hFE00, 1'b0, 3'b111);
        exec("nand", 3'b011, 16'hFFFF, 16'h00F0, 16'hFF0F, 1'b0, 3'b011);
        exec("sub_z", 3'b001, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b100);
        exec("add_neg", 3'b000, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 3'b011);
        exec("sub_pos", 3'b001, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 3'b010);
        exec("ill110", 3'b110, 16'h1234, 16'h0001, 16'h0000, 1'b1, 3'b010);
        exec("add_ok", 3'b000, 16'h1000, 16'h0234, 16'h1234, 1'b0, 3'b000);
        exec("ill111", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 3'b000);

        // Back-pressure: three ADDs against a stalled consumer.
        out_ready = 1'b0;
        op = 3'b000; a = 16'd1; b = 16'd1; in_valid = 1'b1;
        step();
        chk("bp.rdy1", 32'(in_ready), 32'd1);
        a = 16'd2; b = 16'd2;
        step();
        chk("bp.rdy2", 32'(in_ready), 32'd0);
        chk("bp.ov2", 32'(out_valid), 32'd1);
        chk("bp.res1", 32'(result), 32'h0002);
        a = 16'd3; b = 16'd3;
        step();
        chk("bp.hold", 32'(result), 32'h0002);
        chk("bp.rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp.ov4", 32'(out_valid), 32'd1);
        chk("bp.res2", 32'(result), 32'h0004);
        step();
        chk("bp.ov5", 32'(out_valid), 32'd1);
        chk("bp.res3", 32'(result), 32'h0006);
        step();
        chk("bp.ov6", 32'(out_valid), 32'd0);
        chk("bp.flg", 32'(flags), 32'd0);

        // Reset with two ops in flight.
        exec("pre_rst", 3'b000, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 3'b010);
        out_ready = 1'b0;
        op = 3'b000; a = 16'd1; b = 16'd1; in_valid = 1'b1;
        step();
        a = 16'd2; b = 16'd2;
        step();
        in_valid = 1'b0;
        chk("mr.full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("mr.ov", 32'(out_valid), 32'd0);
        chk("mr.flg", 32'(flags), 32'd0);
        chk("mr.res", 32'(result), 32'd0);
        chk("mr.rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr.stale", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
